// File: rtl/latq_bank_wrctl_if.sv
// Request/latch-bank bundle for latq_bank_wrctl: two write requesters in,
// shared data bus and one-hot enables out to the latch array.
interface latq_bank_wrctl_if #(
  parameter int WORDS = 8,
  parameter int WIDTH = 4
);
  localparam int AW = (WORDS > 1) ? $clog2(WORDS) : 1;

  logic             aValid;
  logic [AW-1:0]    aAddr;
  logic [WIDTH-1:0] aData;
  logic             aReady;

  logic             bValid;
  logic [AW-1:0]    bAddr;
  logic [WIDTH-1:0] bData;
  logic             bReady;

  logic [WIDTH-1:0] ld;
  logic [WORDS-1:0] le;
  logic             busy;
  logic             err;

  modport slave (
    input  aValid, aAddr, aData,
    input  bValid, bAddr, bData,
    output aReady, bReady,
    output ld, le, busy, err
  );

  modport master (
    output aValid, aAddr, aData,
    output bValid, bAddr, bData,
    input  aReady, bReady,
    input  ld, le, busy, err
  );
endinterface

// File: rtl/latq_bank_wrctl.sv
// Round-robin write arbiter and setup/enable/hold sequencer for a bank of
// transparent-high latches sharing one data bus.
module latq_bank_wrctl #(
  parameter int WORDS = 8,
  parameter int WIDTH = 4,
  localparam int AW = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  latq_bank_wrctl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ENABLE = 2'd2,
    HOLD   = 2'd3
  } state_e;

  state_e           stateQ, stateD;
  logic [AW-1:0]    addrQ, addrD;
  logic [WIDTH-1:0] ldQ, ldD;
  logic [WORDS-1:0] leQ, leD;
  logic             busyQ, busyD;
  logic             errQ, errD;
  logic             lastGrantBQ, lastGrantBD;
  logic             grantA, grantB;
  logic             inRange;

  // Grant only while idle; on contention the requester not served last wins.
  always_comb begin
    grantA = 1'b0;
    grantB = 1'b0;
    if (stateQ == IDLE) begin
      if (bus.aValid && (!bus.bValid || lastGrantBQ)) begin
        grantA = 1'b1;
      end else if (bus.bValid) begin
        grantB = 1'b1;
      end
    end
  end

  assign inRange = ({1'b0, addrQ} < (AW+1)'(WORDS));

  always_comb begin
    stateD      = stateQ;
    addrD       = addrQ;
    ldD         = ldQ;
    busyD       = busyQ;
    lastGrantBD = lastGrantBQ;
    leD         = '0;
    errD        = 1'b0;
    case (stateQ)
      IDLE: begin
        if (grantA) begin
          addrD       = bus.aAddr;
          ldD         = bus.aData;
          lastGrantBD = 1'b0;
          busyD       = 1'b1;
          stateD      = SETUP;
        end else if (grantB) begin
          addrD       = bus.bAddr;
          ldD         = bus.bData;
          lastGrantBD = 1'b1;
          busyD       = 1'b1;
          stateD      = SETUP;
        end
      end
      // Enable and error flags are prepared here so they leave a flop in ENABLE.
      SETUP: begin
        stateD = ENABLE;
        if (inRange) begin
          leD = WORDS'(1) << addrQ;
        end else begin
          errD = 1'b1;
        end
      end
      ENABLE: begin
        stateD = HOLD;
      end
      HOLD: begin
        stateD = IDLE;
        busyD  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stateQ      <= IDLE;
      addrQ       <= '0;
      ldQ         <= '0;
      leQ         <= '0;
      busyQ       <= 1'b0;
      errQ        <= 1'b0;
      lastGrantBQ <= 1'b1;
    end else begin
      stateQ      <= stateD;
      addrQ       <= addrD;
      ldQ         <= ldD;
      leQ         <= leD;
      busyQ       <= busyD;
      errQ        <= errD;
      lastGrantBQ <= lastGrantBD;
    end
  end

  assign bus.aReady = grantA;
  assign bus.bReady = grantB;
  assign bus.ld     = ldQ;
  assign bus.le     = leQ;
  assign bus.busy   = busyQ;
  assign bus.err    = errQ;

endmodule

// File: tb/tb_latq_bank_wrctl.sv
// Directed bench for latq_bank_wrctl: an 8-word instance for the main flows
// and a 6-word instance for the out-of-range address case.
module tb_latq_bank_wrctl;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  latq_bank_wrctl_if #(.WORDS(8), .WIDTH(4)) bus8 ();
  latq_bank_wrctl_if #(.WORDS(6), .WIDTH(4)) bus6 ();

  latq_bank_wrctl #(.WORDS(8), .WIDTH(4)) dut8 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus8.slave)
  );

  latq_bank_wrctl #(.WORDS(6), .WIDTH(4)) dut6 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus6.slave)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic aV, input logic [2:0] aA, input logic [3:0] aD,
                               input logic bV, input logic [2:0] bA, input logic [3:0] bD);
    bus8.aValid = aV;
    bus8.aAddr  = aA;
    bus8.aData  = aD;
    bus8.bValid = bV;
    bus8.bAddr  = bA;
    bus8.bData  = bD;
    #1;
  endtask

  initial begin
    int         phase;
    logic       lastB, gA, gB, aV, bV, expA;
    logic [2:0] aA, bA, addrExp;
    logic [3:0] aD, bD, ldExp;

    rst = 1'b1;
    bus6.aValid = 1'b0; bus6.aAddr = '0; bus6.aData = '0;
    bus6.bValid = 1'b0; bus6.bAddr = '0; bus6.bData = '0;
    applyStimulus(0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);

    // Reset state
    checkOutput("rstLe", 32'(bus8.le), 0);
    checkOutput("rstLd", 32'(bus8.ld), 0);
    checkOutput("rstBusy", 32'(bus8.busy), 0);
    checkOutput("rstErr", 32'(bus8.err), 0);
    rst = 1'b0;

    // Single write: A addr 3 data A
    applyStimulus(1, 3, 4'hA, 0, 0, 0);
    checkOutput("t1aReady", 32'(bus8.aReady), 1);
    checkOutput("t1bReady", 32'(bus8.bReady), 0);
    @(negedge clk);
    applyStimulus(0, 3, 4'hA, 0, 0, 0);
    checkOutput("t1setupLd", 32'(bus8.ld), 'hA);
    checkOutput("t1setupLe", 32'(bus8.le), 0);
    checkOutput("t1setupBusy", 32'(bus8.busy), 1);
    @(negedge clk);
    checkOutput("t1enableLe", 32'(bus8.le), 'h08);
    checkOutput("t1enableErr", 32'(bus8.err), 0);
    checkOutput("t1enableBusy", 32'(bus8.busy), 1);
    @(negedge clk);
    checkOutput("t1holdLe", 32'(bus8.le), 0);
    checkOutput("t1holdLd", 32'(bus8.ld), 'hA);
    checkOutput("t1holdBusy", 32'(bus8.busy), 1);
    @(negedge clk);
    checkOutput("t1idleBusy", 32'(bus8.busy), 0);
    checkOutput("t1idleLd", 32'(bus8.ld), 'hA);

    // Contention from reset: A first, then B in its first idle cycle
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1, 1, 5, 1, 2, 6);
    checkOutput("t2aReady", 32'(bus8.aReady), 1);
    checkOutput("t2bReady", 32'(bus8.bReady), 0);
    @(negedge clk);
    applyStimulus(0, 1, 5, 1, 2, 6);
    checkOutput("t2ldA", 32'(bus8.ld), 5);
    checkOutput("t2bWaits", 32'(bus8.bReady), 0);
    @(negedge clk);
    checkOutput("t2leA", 32'(bus8.le), 'h02);
    @(negedge clk);
    checkOutput("t2holdA", 32'(bus8.le), 0);
    @(negedge clk);
    checkOutput("t2bReadyIdle", 32'(bus8.bReady), 1);
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 2, 6);
    checkOutput("t2ldB", 32'(bus8.ld), 6);
    @(negedge clk);
    checkOutput("t2leB", 32'(bus8.le), 'h04);
    @(negedge clk);
    @(negedge clk);
    checkOutput("t2idleBusy", 32'(bus8.busy), 0);

    // Fairness: both held valid, grants alternate A,B,A,B
    applyStimulus(1, 1, 5, 1, 2, 6);
    for (int k = 0; k < 8; k++) begin
      expA = (k % 2 == 0);
      checkOutput("fairA", 32'(bus8.aReady), 32'(expA));
      checkOutput("fairB", 32'(bus8.bReady), 32'(!expA));
      @(negedge clk);
      checkOutput("fairLd", 32'(bus8.ld), expA ? 5 : 6);
      checkOutput("fairBusyRdy", 32'(bus8.aReady | bus8.bReady), 0);
      @(negedge clk);
      checkOutput("fairLe", 32'(bus8.le), expA ? 'h02 : 'h04);
      @(negedge clk);
      checkOutput("fairHoldRdy", 32'(bus8.aReady | bus8.bReady), 0);
      @(negedge clk);
    end
    applyStimulus(0, 0, 0, 0, 0, 0);
    @(negedge clk);

    // Out of range on the 6-word bank
    bus6.bValid = 1'b1; bus6.bAddr = 3'd7; bus6.bData = 4'h3;
    #1;
    checkOutput("oorReady", 32'(bus6.bReady), 1);
    @(negedge clk);
    bus6.bValid = 1'b0;
    checkOutput("oorSetupErr", 32'(bus6.err), 0);
    checkOutput("oorLd", 32'(bus6.ld), 3);
    @(negedge clk);
    checkOutput("oorErr", 32'(bus6.err), 1);
    checkOutput("oorLe", 32'(bus6.le), 0);
    @(negedge clk);
    checkOutput("oorErrGone", 32'(bus6.err), 0);
    checkOutput("oorHoldBusy", 32'(bus6.busy), 1);
    @(negedge clk);
    checkOutput("oorIdleBusy", 32'(bus6.busy), 0);
    bus6.aValid = 1'b1; bus6.aAddr = 3'd5; bus6.aData = 4'h1;
    #1;
    checkOutput("oorNextReady", 32'(bus6.aReady), 1);
    @(negedge clk);
    bus6.aValid = 1'b0;
    @(negedge clk);
    checkOutput("w6LeTop", 32'(bus6.le), 'h20);
    checkOutput("w6Err", 32'(bus6.err), 0);
    repeat (2) @(negedge clk);

    // Reset during ENABLE after an A grant
    applyStimulus(1, 5, 9, 0, 0, 0);
    checkOutput("rmAReady", 32'(bus8.aReady), 1);
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("rmLe", 32'(bus8.le), 'h20);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rmLeAfter", 32'(bus8.le), 0);
    checkOutput("rmBusyAfter", 32'(bus8.busy), 0);
    checkOutput("rmLdAfter", 32'(bus8.ld), 0);
    rst = 1'b0;
    applyStimulus(1, 1, 5, 1, 2, 6);
    checkOutput("rmAFirst", 32'(bus8.aReady), 1);
    checkOutput("rmBWaits", 32'(bus8.bReady), 0);
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);

    // Random valids and changing data, checked against a cycle model
    phase   = 0;
    lastB   = 1'b0;
    ldExp   = 4'd5;
    addrExp = 3'd1;
    for (int i = 0; i < 40; i++) begin
      aV = 1'($urandom_range(0, 1));
      bV = 1'($urandom_range(0, 1));
      aA = 3'($urandom_range(0, 7));
      bA = 3'($urandom_range(0, 7));
      aD = 4'($urandom_range(0, 15));
      bD = 4'($urandom_range(0, 15));
      applyStimulus(aV, aA, aD, bV, bA, bD);
      gA = (phase == 0) && aV && (!bV || lastB);
      gB = (phase == 0) && bV && !gA;
      checkOutput("rndAReady", 32'(bus8.aReady), 32'(gA));
      checkOutput("rndBReady", 32'(bus8.bReady), 32'(gB));
      @(negedge clk);
      if (gA) begin
        phase = 1; ldExp = aD; addrExp = aA; lastB = 1'b0;
      end else if (gB) begin
        phase = 1; ldExp = bD; addrExp = bA; lastB = 1'b1;
      end else if (phase != 0) begin
        phase = (phase + 1) % 4;
      end
      checkOutput("rndLe", 32'(bus8.le), (phase == 2) ? (32'd1 << addrExp) : 0);
      checkOutput("rndLd", 32'(bus8.ld), 32'(ldExp));
      checkOutput("rndBusy", 32'(bus8.busy), 32'(phase != 0));
      checkOutput("rndOneHot", 32'($countones(bus8.le) <= 1), 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
